pc_fetch_btb: RTL and testbench
===============================

// Module: pc_fetch_btb
// PURPOSE
// - Parametrised PC/fetch-redirect unit for the 5-stage MIPS pipeline; replaces the single PC register plus next-PC mux.
// - Predicts next PC in IF with a direct-mapped branch target buffer (BTB) holding 2-bit saturating counters.
// - Resolves predictions against EX outcomes, redirects on mispredict or exception, and keeps performance counters.
// PARAMETERS
// - XLEN          32             address/data width
// - BTB_ENTRIES   16             BTB entries; power of 2, >=2; IDXW=log2(BTB_ENTRIES)
// - RESET_VECTOR  32'h80000000   PC after reset
// - ILLOP_VECTOR  32'h80000004   target for illegal-op exception
// - XADR_VECTOR   32'h80000008   target for interrupt/other exception
// - CNT_W         16             width of performance counters
// PORTS
// - clk              in   1      clock
// - reset            in   1      asynchronous, active-high reset
// - stall_i          in   1      hold PC (load-use hazard; inverse of PC write enable)
// - ex_valid_i       in   1      EX holds a real, unflushed instruction
// - ex_is_branch_i   in   1      EX instr is beq/bne
// - ex_is_jump_i     in   1      EX instr is j/jal (direct target)
// - ex_taken_i       in   1      actual branch outcome (1 for jumps)
// - ex_pc_i          in   XLEN   PC of EX instruction
// - ex_target_i      in   XLEN   actual target (ConBA or JT)
// - ex_pred_taken_i  in   1      prediction carried down pipe with the instr
// - ex_pred_target_i in   XLEN   predicted target carried down pipe
// - exc_i            in   1      take exception this cycle
// - exc_illop_i      in   1      1: ILLOP_VECTOR, 0: XADR_VECTOR (valid with exc_i)
// - pc_o             out  XLEN   current fetch PC
// - pred_taken_o     out  1      IF prediction for pc_o
// - pred_target_o    out  XLEN   IF predicted target for pc_o
// - redirect_o       out  1      flush IF/ID and ID/EX this cycle
// - branch_cnt_o     out  CNT_W  resolved branches+jumps, saturating
// - mispred_cnt_o    out  CNT_W  mispredicts, saturating
// BEHAVIOUR
// - Reset (async): pc_o=RESET_VECTOR; all BTB valid=0, counters=2'b01; counters_o=0; outputs combinationally derived then give pred_taken_o=0, redirect_o=0.
// - Lookup (comb, 0 latency): idx=pc_o[IDXW+1:2], tag=pc_o[XLEN-1:IDXW+2]; hit=valid&&tag match.
//   pred_taken_o = hit && ctr[1]; pred_target_o = hit ? target : pc_o+4.
// - Mispredict (comb): mis = ex_valid_i && (ex_is_branch_i||ex_is_jump_i) &&
//   (ex_taken_i!=ex_pred_taken_i || (ex_taken_i && ex_target_i!=ex_pred_target_i)).
//   fix_pc = ex_taken_i ? ex_target_i : ex_pc_i+4.
// - redirect_o = exc_i || mis.
// - Next-PC priority at posedge: exc_i (vector) > mis (fix_pc) > stall_i (hold) > pred_target_o.
//   Redirect overrides stall. Stall never blocks BTB update or counters.
// - BTB update at posedge when ex_valid_i && (branch||jump), EX index/tag from ex_pc_i:
//   - Hit: ctr saturating +1 if taken, -1 if not (11 and 00 sticky); target<=ex_target_i if taken.
//   - Miss & taken: allocate/overwrite; valid=1; ctr=2'b11 for jump, 2'b10 for branch.
//   - Miss & not taken: no change.
// - Same-cycle lookup and update of one index: lookup sees pre-edge contents (write-first not used).
// - exc_i and EX update same cycle: update still performed (instr resolved before exception).
// - Arithmetic: +4 wraps mod 2^XLEN; targets stored/used with bits[1:0] forced 0.
// - branch_cnt_o +1 per resolved branch/jump; mispred_cnt_o +1 per mis; both saturate at all-ones.
// - Reset mid-operation: immediate return to reset state; pending EX update discarded.
// STRUCTURE
// - Shared package cpu_pkg: reset/ILLOP/XADR vector constants, PCSrc encodings, 2-bit counter encodings (SNT=00,WNT=01,WT=10,ST=11).
// - One sub-module: btb_bank (valid/tag/target/ctr arrays, async-clear valids, comb read port, one sync write port).
// - Top holds PC register, mispredict compare, next-PC mux, perf counters.
// TESTING
// - Reset: assert reset mid-run -> pc_o=32'h80000000, pred_taken_o=0, counters 0, prior BTB hits gone.
// - Cold branch: beq at 80000010 taken to 80000040, pred 0 -> redirect_o=1, next pc_o=80000040, entry ctr=10; refetch 80000010 -> pred_taken_o=1, pred_target_o=80000040.
// - Hysteresis: same branch not-taken once (ctr 10->01, mispredict), taken -> ctr 10; verify pred flips and mispred_cnt_o increments each.
// - Stall vs redirect: stall_i=1 with no mis -> pc_o held; stall_i=1 with mis -> pc_o=fix_pc.
// - Exception priority: exc_i=1, exc_illop_i=1, simultaneous mis -> pc_o=80000004, BTB still updated.
// - Aliasing (BTB_ENTRIES=4): branches at 80000000 and 80000010 share idx 0 -> second allocation evicts first; lookup of first misses.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: exception vectors, next-PC source encodings and
// 2-bit branch-predictor counter states with their saturating update.
package cpu_pkg;

  localparam logic [31:0] RESET_VECTOR_C = 32'h8000_0000;
  localparam logic [31:0] ILLOP_VECTOR_C = 32'h8000_0004;
  localparam logic [31:0] XADR_VECTOR_C  = 32'h8000_0008;

  typedef enum logic [1:0] {
    PCSRC_PRED = 2'd0,
    PCSRC_HOLD = 2'd1,
    PCSRC_FIX  = 2'd2,
    PCSRC_EXC  = 2'd3
  } pcsrc_e;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  function automatic ctr_e ctr_next(input ctr_e cur, input logic taken);
    ctr_e nxt;
    nxt = cur;
    if (taken) begin
      if (cur != CTR_ST) nxt = ctr_e'(cur + 2'd1);
    end else begin
      if (cur != CTR_SNT) nxt = ctr_e'(cur - 2'd1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pc_fetch_btb_bank.sv
// Direct-mapped BTB storage: valid/tag/target/counter arrays with one
// combinational lookup port and one synchronous resolve/update port.
module btb_bank
  import cpu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int IDXW = 4,
  parameter int TAGW = XLEN - IDXW - 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IDXW-1:0] rd_idx_i,
  input  logic [TAGW-1:0] rd_tag_i,
  output logic            rd_hit_o,
  output ctr_e            rd_ctr_o,
  output logic [XLEN-1:0] rd_target_o,
  input  logic            upd_en_i,
  input  logic [IDXW-1:0] upd_idx_i,
  input  logic [TAGW-1:0] upd_tag_i,
  input  logic            upd_taken_i,
  input  logic            upd_jump_i,
  input  logic [XLEN-1:0] upd_target_i
);

  localparam int ENTRIES = 1 << IDXW;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic            valid_q [ENTRIES];
  ctr_e            ctr_q   [ENTRIES];
  logic [TAGW-1:0] tag_q   [ENTRIES];
  logic [XLEN-1:0] tgt_q   [ENTRIES];

  logic upd_hit;

  assign rd_hit_o    = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
  assign rd_ctr_o    = ctr_q[rd_idx_i];
  assign rd_target_o = tgt_q[rd_idx_i];

  assign upd_hit = valid_q[upd_idx_i] && (tag_q[upd_idx_i] == upd_tag_i);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WNT;
      end
    end else if (upd_en_i) begin
      if (upd_hit) begin
        ctr_q[upd_idx_i] <= ctr_next(ctr_q[upd_idx_i], upd_taken_i);
      end else if (upd_taken_i) begin
        valid_q[upd_idx_i] <= 1'b1;
        ctr_q[upd_idx_i]   <= upd_jump_i ? CTR_ST : CTR_WT;
      end
    end
  end

  // Tag/target need no reset: they are qualified by valid_q. A taken
  // resolve rewrites the same tag on a hit and allocates on a miss.
  always_ff @(posedge clk) begin
    if (upd_en_i && upd_taken_i) begin
      tag_q[upd_idx_i] <= upd_tag_i;
      tgt_q[upd_idx_i] <= upd_target_i & ALIGN_MASK;
    end
  end

endmodule

// File: rtl/pc_fetch_btb.sv
// Fetch PC register with BTB-based next-PC prediction, EX-stage mispredict
// recovery, exception redirect and saturating branch/mispredict counters.
module pc_fetch_btb
  import cpu_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter int              BTB_ENTRIES  = 16,
  parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_C,
  parameter logic [XLEN-1:0] ILLOP_VECTOR = ILLOP_VECTOR_C,
  parameter logic [XLEN-1:0] XADR_VECTOR  = XADR_VECTOR_C,
  parameter int              CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_i,
  input  logic             ex_valid_i,
  input  logic             ex_is_branch_i,
  input  logic             ex_is_jump_i,
  input  logic             ex_taken_i,
  input  logic [XLEN-1:0]  ex_pc_i,
  input  logic [XLEN-1:0]  ex_target_i,
  input  logic             ex_pred_taken_i,
  input  logic [XLEN-1:0]  ex_pred_target_i,
  input  logic             exc_i,
  input  logic             exc_illop_i,
  output logic [XLEN-1:0]  pc_o,
  output logic             pred_taken_o,
  output logic [XLEN-1:0]  pred_target_o,
  output logic             redirect_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam int IDXW = $clog2(BTB_ENTRIES);
  localparam int TAGW = XLEN - IDXW - 2;
  localparam logic [XLEN-1:0] FOUR       = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic            lk_hit;
  ctr_e            lk_ctr;
  logic [XLEN-1:0] lk_target;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pred_next;

  logic            ex_resolve;
  logic [XLEN-1:0] ex_tgt_al;
  logic [XLEN-1:0] ex_pred_tgt_al;
  logic            mis;
  logic [XLEN-1:0] fix_pc;
  logic [XLEN-1:0] exc_vec;
  pcsrc_e          pc_src;

  btb_bank #(
    .XLEN (XLEN),
    .IDXW (IDXW),
    .TAGW (TAGW)
  ) u_bank (
    .clk          (clk),
    .reset        (reset),
    .rd_idx_i     (pc_q[IDXW+1:2]),
    .rd_tag_i     (pc_q[XLEN-1:IDXW+2]),
    .rd_hit_o     (lk_hit),
    .rd_ctr_o     (lk_ctr),
    .rd_target_o  (lk_target),
    .upd_en_i     (ex_resolve),
    .upd_idx_i    (ex_pc_i[IDXW+1:2]),
    .upd_tag_i    (ex_pc_i[XLEN-1:IDXW+2]),
    .upd_taken_i  (ex_taken_i),
    .upd_jump_i   (ex_is_jump_i),
    .upd_target_i (ex_target_i)
  );

  assign pc_plus4      = pc_q + FOUR;
  assign pred_taken_o  = lk_hit && lk_ctr[1];
  assign pred_target_o = lk_hit ? lk_target : pc_plus4;
  // Only follow the stored target when it is predicted taken, so the
  // fetched path always matches the pred_taken bit carried down the pipe.
  assign pred_next     = pred_taken_o ? pred_target_o : pc_plus4;

  assign ex_resolve     = ex_valid_i && (ex_is_branch_i || ex_is_jump_i);
  assign ex_tgt_al      = ex_target_i & ALIGN_MASK;
  assign ex_pred_tgt_al = ex_pred_target_i & ALIGN_MASK;
  assign mis = ex_resolve &&
               ((ex_taken_i != ex_pred_taken_i) ||
                (ex_taken_i && (ex_tgt_al != ex_pred_tgt_al)));
  assign fix_pc     = ex_taken_i ? ex_tgt_al : (ex_pc_i + FOUR);
  assign exc_vec    = exc_illop_i ? ILLOP_VECTOR : XADR_VECTOR;
  assign redirect_o = exc_i || mis;

  always_comb begin
    pc_src = PCSRC_PRED;
    if (exc_i)        pc_src = PCSRC_EXC;
    else if (mis)     pc_src = PCSRC_FIX;
    else if (stall_i) pc_src = PCSRC_HOLD;
  end

  always_comb begin
    pc_d = pred_next;
    case (pc_src)
      PCSRC_EXC:  pc_d = exc_vec;
      PCSRC_FIX:  pc_d = fix_pc;
      PCSRC_HOLD: pc_d = pc_q;
      default:    pc_d = pred_next;
    endcase
  end

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (ex_resolve && (branch_cnt_q != '1)) branch_cnt_d = branch_cnt_q + 1'b1;
    if (mis && (mispred_cnt_q != '1))      mispred_cnt_d = mispred_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_VECTOR;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      pc_q          <= pc_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign pc_o          = pc_q;
  assign branch_cnt_o  = branch_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_pc_fetch_btb.sv
// Directed scoreboard bench for pc_fetch_btb with a 4-entry BTB so that
// 80000000 and 80000010 alias onto index 0.
module tb_pc_fetch_btb;

  localparam int K_PC = 0, K_PT = 1, K_PTG = 2, K_RD = 3, K_BC = 4, K_MC = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i, ex_valid_i, ex_is_branch_i, ex_is_jump_i, ex_taken_i;
  logic [31:0] ex_pc_i, ex_target_i, ex_pred_target_i;
  logic        ex_pred_taken_i, exc_i, exc_illop_i;
  logic [31:0] pc_o, pred_target_o;
  logic        pred_taken_o, redirect_o;
  logic [15:0] branch_cnt_o, mispred_cnt_o;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int fails = 0;
  int eb = 0;
  int em = 0;

  pc_fetch_btb #(.XLEN(32), .BTB_ENTRIES(4), .CNT_W(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .stall_i          (stall_i),
    .ex_valid_i       (ex_valid_i),
    .ex_is_branch_i   (ex_is_branch_i),
    .ex_is_jump_i     (ex_is_jump_i),
    .ex_taken_i       (ex_taken_i),
    .ex_pc_i          (ex_pc_i),
    .ex_target_i      (ex_target_i),
    .ex_pred_taken_i  (ex_pred_taken_i),
    .ex_pred_target_i (ex_pred_target_i),
    .exc_i            (exc_i),
    .exc_illop_i      (exc_illop_i),
    .pc_o             (pc_o),
    .pred_taken_o     (pred_taken_o),
    .pred_target_o    (pred_target_o),
    .redirect_o       (redirect_o),
    .branch_cnt_o     (branch_cnt_o),
    .mispred_cnt_o    (mispred_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      K_PC:    return pc_o;
      K_PT:    return {31'b0, pred_taken_o};
      K_PTG:   return pred_target_o;
      K_RD:    return {31'b0, redirect_o};
      K_BC:    return {16'b0, branch_cnt_o};
      default: return {16'b0, mispred_cnt_o};
    endcase
  endfunction

  task automatic push(input string tag, input int kind, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.kind = kind;
    e.val = v;
    q.push_back(e);
  endtask

  task automatic push_cnt(input string tag);
    push({tag, "_bcnt"}, K_BC, 32'(eb));
    push({tag, "_mcnt"}, K_MC, 32'(em));
  endtask

  task automatic check_q();
    exp_t e;
    logic [31:0] o;
    while (q.size() > 0) begin
      e = q.pop_front();
      o = observe(e.kind);
      total++;
      assert (o === e.val) else begin
        fails++;
        $error("FAIL %s observed=%h expected=%h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic idle();
    ex_valid_i = 1'b0; ex_is_branch_i = 1'b0; ex_is_jump_i = 1'b0;
    ex_taken_i = 1'b0; ex_pc_i = 32'h0; ex_target_i = 32'h0;
    ex_pred_taken_i = 1'b0; ex_pred_target_i = 32'h0;
    exc_i = 1'b0; exc_illop_i = 1'b0;
  endtask

  task automatic drive_ex(input logic jump, input logic taken, input logic [31:0] pc,
                          input logic [31:0] tgt, input logic ptaken, input logic [31:0] ptgt);
    ex_valid_i = 1'b1; ex_is_branch_i = ~jump; ex_is_jump_i = jump;
    ex_taken_i = taken; ex_pc_i = pc; ex_target_i = tgt;
    ex_pred_taken_i = ptaken; ex_pred_target_i = ptgt;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Not-taken branch at addr-4 that was predicted taken: mispredict to addr.
  task automatic redir_to(input logic [31:0] addr);
    drive_ex(1'b0, 1'b0, addr - 32'd4, 32'h0, 1'b1, addr + 32'h100);
    #1;
    push("redir_rd", K_RD, 32'd1);
    check_q();
    cyc();
    idle();
    eb++; em++;
    push("redir_pc", K_PC, addr);
    push_cnt("redir");
    check_q();
  endtask

  initial begin
    reset = 1'b1;
    stall_i = 1'b0;
    idle();
    #12 reset = 1'b0;
    #1;
    push("rst_pc", K_PC, 32'h8000_0000);
    push("rst_pt", K_PT, 32'd0);
    push("rst_ptg", K_PTG, 32'h8000_0004);
    push("rst_rd", K_RD, 32'd0);
    push_cnt("rst");
    check_q();

    // Cold taken branch at 80000010 predicted not-taken
    drive_ex(1'b0, 1'b1, 32'h8000_0010, 32'h8000_0040, 1'b0, 32'h8000_0014);
    #1;
    push("cold_rd", K_RD, 32'd1);
    check_q();
    cyc(); idle(); eb++; em++;
    push("cold_pc", K_PC, 32'h8000_0040);
    push_cnt("cold");
    check_q();

    redir_to(32'h8000_0010);
    #1;
    push("refetch_pt", K_PT, 32'd1);
    push("refetch_ptg", K_PTG, 32'h8000_0040);
    check_q();
    cyc();
    push("follow_pc", K_PC, 32'h8000_0040);
    check_q();

    // Hysteresis: not-taken once (10->01), then taken (01->10)
    drive_ex(1'b0, 1'b0, 32'h8000_0010, 32'h0, 1'b1, 32'h8000_0040);
    #1;
    push("hyst_nt_rd", K_RD, 32'd1);
    check_q();
    cyc(); idle(); eb++; em++;
    push("hyst_nt_pc", K_PC, 32'h8000_0014);
    push_cnt("hyst_nt");
    check_q();

    redir_to(32'h8000_0010);
    #1;
    push("hyst_wnt_pt", K_PT, 32'd0);
    push("hyst_wnt_ptg", K_PTG, 32'h8000_0040);
    check_q();

    drive_ex(1'b0, 1'b1, 32'h8000_0010, 32'h8000_0040, 1'b0, 32'h8000_0014);
    #1;
    push("hyst_t_rd", K_RD, 32'd1);
    push("same_cycle_pt", K_PT, 32'd0);
    check_q();
    cyc(); idle(); eb++; em++;
    push("hyst_t_pc", K_PC, 32'h8000_0040);
    push_cnt("hyst_t");
    check_q();

    redir_to(32'h8000_0010);
    #1;
    push("hyst_wt_pt", K_PT, 32'd1);
    check_q();

    // Stall without and with mispredict
    stall_i = 1'b1;
    cyc();
    push("stall_pc", K_PC, 32'h8000_0010);
    push_cnt("stall");
    check_q();
    drive_ex(1'b1, 1'b1, 32'h8000_0024, 32'h8000_0100, 1'b0, 32'h8000_0028);
    #1;
    push("stall_mis_rd", K_RD, 32'd1);
    check_q();
    cyc(); idle(); stall_i = 1'b0; eb++; em++;
    push("stall_mis_pc", K_PC, 32'h8000_0100);
    push_cnt("stall_mis");
    check_q();

    // Exception beats simultaneous mispredict; BTB still updated (10->01)
    drive_ex(1'b0, 1'b0, 32'h8000_0010, 32'h0, 1'b1, 32'h8000_0040);
    exc_i = 1'b1; exc_illop_i = 1'b1;
    #1;
    push("exc_rd", K_RD, 32'd1);
    check_q();
    cyc(); idle(); eb++; em++;
    push("exc_pc", K_PC, 32'h8000_0004);
    push_cnt("exc");
    check_q();
    redir_to(32'h8000_0010);
    #1;
    push("exc_upd_pt", K_PT, 32'd0);
    check_q();

    exc_i = 1'b1; exc_illop_i = 1'b0;
    #1;
    push("xadr_rd", K_RD, 32'd1);
    check_q();
    cyc(); idle();
    push("xadr_pc", K_PC, 32'h8000_0008);
    push_cnt("xadr");
    check_q();

    // Aliasing: 80000000 evicts 80000010 from index 0
    drive_ex(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0080, 1'b0, 32'h8000_0004);
    cyc(); idle(); eb++; em++;
    push("alias_pc", K_PC, 32'h8000_0080);
    push_cnt("alias");
    check_q();
    redir_to(32'h8000_0010);
    #1;
    push("alias_old_pt", K_PT, 32'd0);
    push("alias_old_ptg", K_PTG, 32'h8000_0014);
    check_q();
    redir_to(32'h8000_0000);
    #1;
    push("alias_new_pt", K_PT, 32'd1);
    push("alias_new_ptg", K_PTG, 32'h8000_0080);
    check_q();

    // Correctly predicted branch: no redirect, follow prediction
    drive_ex(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0080, 1'b1, 32'h8000_0080);
    #1;
    push("good_rd", K_RD, 32'd0);
    check_q();
    cyc(); idle(); eb++;
    push("good_pc", K_PC, 32'h8000_0080);
    push_cnt("good");
    check_q();

    // Jump allocated strongly taken
    redir_to(32'h8000_0024);
    #1;
    push("jmp_pt", K_PT, 32'd1);
    push("jmp_ptg", K_PTG, 32'h8000_0100);
    check_q();
    cyc();
    push("jmp_pc", K_PC, 32'h8000_0100);
    check_q();

    // Reset mid-run, off the clock edge
    redir_to(32'h8000_0000);
    #2 reset = 1'b1;
    #1;
    eb = 0; em = 0;
    push("mrst_pc", K_PC, 32'h8000_0000);
    push("mrst_pt", K_PT, 32'd0);
    push_cnt("mrst");
    check_q();
    #3 reset = 1'b0;
    #1;
    push("mrst_ptg", K_PTG, 32'h8000_0004);
    push("mrst_pt2", K_PT, 32'd0);
    check_q();

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
